// File: rtl/wb_ram_slave_pkg.sv
// Shared types and constants for the Wishbone classic-cycle RAM slave.
package wb_ram_slave_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int CNT_W = 4;
  localparam int LANES = 4;

endpackage

// File: rtl/wb_ram_slave_mem.sv
// Single-port RAM with per-byte write enables and a registered read port.
module wb_ram_slave_mem
  import wb_ram_slave_pkg::*;
#(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AWIDTH-1:0] addr,
  input  logic [DWIDTH-1:0] wdata,
  input  logic [LANES-1:0]  sel,
  input  logic              we,
  input  logic              re,
  output logic [DWIDTH-1:0] rdata
);

  logic [DWIDTH-1:0] ram [2**AWIDTH];

  // Array contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < LANES; i++) begin
        if (sel[i]) ram[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // Read register holds its value until the next acked read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= ram[addr];
    end
  end

endmodule

// File: rtl/wb_ram_slave.sv
// Wishbone classic-cycle RAM slave: wait states, byte-lane writes, ERR on
// out-of-range addresses and RTY while the array is held off.
module wb_ram_slave
  import wb_ram_slave_pkg::*;
#(
  parameter int DWIDTH      = 32,
  parameter int AWIDTH      = 8,
  parameter int WAIT_STATES = 1
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic [DWIDTH-1:0] wb_data_i,
  output logic [DWIDTH-1:0] wb_data_o,
  input  logic [31:0]       wb_addr_i,
  input  logic [LANES-1:0]  wb_sel_i,
  input  logic              wb_we_i,
  input  logic              wb_cyc_i,
  input  logic              wb_stb_i,
  output logic              wb_ack_o,
  output logic              wb_err_o,
  output logic              wb_rty_o,
  input  logic              hold_i
);

  localparam logic [CNT_W-1:0] WS_LOAD =
    (WAIT_STATES > 0) ? CNT_W'(WAIT_STATES - 1) : '0;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             req;
  logic             oor;
  logic             commit;
  logic             unused_ok;

  assign unused_ok = &{1'b0, wb_addr_i[1:0]};

  always_comb begin
    req    = wb_cyc_i & wb_stb_i & ~(wb_ack_o | wb_err_o | wb_rty_o);
    oor    = |wb_addr_i[31:AWIDTH+2];
    commit = 1'b0;
    case (state)
      IDLE:    commit = req & ~oor & ~hold_i & (WAIT_STATES == 0);
      WAIT:    commit = wb_cyc_i & wb_stb_i & (cnt == '0);
      default: commit = 1'b0;
    endcase
  end

  // Terminations are registered and live only in RESP, so each lasts one cycle.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state    <= IDLE;
      cnt      <= '0;
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      wb_rty_o <= 1'b0;
    end else begin
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      wb_rty_o <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            if (oor) begin
              wb_err_o <= 1'b1;
              state    <= RESP;
            end else if (hold_i) begin
              wb_rty_o <= 1'b1;
              state    <= RESP;
            end else if (commit) begin
              wb_ack_o <= 1'b1;
              state    <= RESP;
            end else begin
              cnt   <= WS_LOAD;
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          // hold_i no longer matters here; only an abort by the master stops the access.
          if (!(wb_cyc_i && wb_stb_i)) begin
            state <= IDLE;
          end else if (cnt == '0) begin
            wb_ack_o <= 1'b1;
            state    <= RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  wb_ram_slave_mem #(
    .DWIDTH (DWIDTH),
    .AWIDTH (AWIDTH)
  ) u_mem (
    .clk   (wb_clk_i),
    .rst   (wb_rst_i),
    .addr  (wb_addr_i[AWIDTH+1:2]),
    .wdata (wb_data_i),
    .sel   (wb_sel_i),
    .we    (commit & wb_we_i),
    .re    (commit & ~wb_we_i),
    .rdata (wb_data_o)
  );

endmodule
